// File: rtl/obi_mux_credit.sv
// N-to-1 OBI multiplexer with per-port credit limits,
// round-robin or fixed-priority arbitration, FIFO or ID response routing.
module obi_mux_credit #(
  parameter int NumSbrPorts     = 4,
  parameter int AddrWidth       = 32,
  parameter int DataWidth       = 32,
  parameter int SbrIdWidth      = 1,
  parameter int MgrIdWidth      = SbrIdWidth + $clog2(NumSbrPorts),
  parameter int MaxTransPerPort = 4,
  parameter int NumMaxTrans     = 8,
  parameter int PriorityMode    = 0,
  parameter int UseIdForRouting = 0,
  parameter int UseRReady       = 1,
  localparam int BeWidth  = DataWidth / 8,
  localparam int CntWidth = $clog2(MaxTransPerPort + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumSbrPorts-1:0]              sbr_req_i,
  output logic [NumSbrPorts-1:0]              sbr_gnt_o,
  input  logic [NumSbrPorts*AddrWidth-1:0]    sbr_addr_i,
  input  logic [NumSbrPorts-1:0]              sbr_we_i,
  input  logic [NumSbrPorts*BeWidth-1:0]      sbr_be_i,
  input  logic [NumSbrPorts*DataWidth-1:0]    sbr_wdata_i,
  input  logic [NumSbrPorts*SbrIdWidth-1:0]   sbr_aid_i,
  output logic [NumSbrPorts-1:0]              sbr_rvalid_o,
  input  logic [NumSbrPorts-1:0]              sbr_rready_i,
  output logic [DataWidth-1:0]                sbr_rdata_o,
  output logic                                sbr_err_o,
  output logic [SbrIdWidth-1:0]               sbr_rid_o,
  output logic                                mgr_req_o,
  input  logic                                mgr_gnt_i,
  output logic [AddrWidth-1:0]                mgr_addr_o,
  output logic                                mgr_we_o,
  output logic [BeWidth-1:0]                  mgr_be_o,
  output logic [DataWidth-1:0]                mgr_wdata_o,
  output logic [MgrIdWidth-1:0]               mgr_aid_o,
  input  logic                                mgr_rvalid_i,
  output logic                                mgr_rready_o,
  input  logic [DataWidth-1:0]                mgr_rdata_i,
  input  logic                                mgr_err_i,
  input  logic [MgrIdWidth-1:0]               mgr_rid_i,
  output logic [NumSbrPorts*CntWidth-1:0]     outstanding_o,
  output logic                                spurious_rsp_o
);

  localparam int PortWidth = $clog2(NumSbrPorts);
  localparam int TotWidth  = $clog2(NumMaxTrans + 1);
  localparam int PtrWidth  = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

  if (NumSbrPorts < 2) begin : g_err_ports
    $fatal(1, "obi_mux_credit: NumSbrPorts must be >= 2");
  end
  if (MaxTransPerPort < 1) begin : g_err_credit
    $fatal(1, "obi_mux_credit: MaxTransPerPort must be >= 1");
  end
  if (MgrIdWidth < SbrIdWidth + PortWidth) begin : g_err_id
    $fatal(1, "obi_mux_credit: MgrIdWidth too small");
  end

  logic [CntWidth-1:0]    cnt_q [NumSbrPorts];
  logic [TotWidth-1:0]    total_q;
  logic [PortWidth-1:0]   rr_q;
  logic [PortWidth-1:0]   lock_sel_q;
  logic                   lock_q;
  logic                   spurious_q;

  logic [NumSbrPorts-1:0] elig;
  logic [NumSbrPorts-1:0] inc_vec;
  logic [NumSbrPorts-1:0] dec_vec;
  logic [PortWidth-1:0]   arb_sel;
  logic [PortWidth-1:0]   sel;
  logic [PortWidth-1:0]   rsp_idx;
  logic                   room;
  logic                   accept;
  logic                   no_route;
  logic                   rsp_hs;

  // Total below the limit also means the index FIFO has space.
  assign room = total_q < TotWidth'(NumMaxTrans);

  always_comb begin
    elig = '0;
    for (int p = 0; p < NumSbrPorts; p++) begin
      elig[p] = sbr_req_i[p] && room &&
                (cnt_q[p] < CntWidth'(MaxTransPerPort));
    end
  end

  always_comb begin
    int  j;
    logic found;
    arb_sel = '0;
    found   = 1'b0;
    j       = 0;
    if (PriorityMode != 0) begin
      for (int i = NumSbrPorts - 1; i >= 0; i--) begin
        if (elig[i]) arb_sel = PortWidth'(i);
      end
    end else begin
      for (int i = 0; i < NumSbrPorts; i++) begin
        j = int'(rr_q) + i;
        if (j >= NumSbrPorts) j = j - NumSbrPorts;
        if (!found && elig[j]) begin
          found   = 1'b1;
          arb_sel = PortWidth'(j);
        end
      end
    end
  end

  // A stalled request keeps its port until the manager grants it.
  assign sel       = lock_q ? lock_sel_q : arb_sel;
  assign mgr_req_o = elig[sel];
  assign accept    = mgr_req_o & mgr_gnt_i;

  always_comb begin
    sbr_gnt_o      = '0;
    sbr_gnt_o[sel] = accept;
  end

  assign mgr_addr_o  = sbr_addr_i[sel*AddrWidth +: AddrWidth];
  assign mgr_we_o    = sbr_we_i[sel];
  assign mgr_be_o    = sbr_be_i[sel*BeWidth +: BeWidth];
  assign mgr_wdata_o = sbr_wdata_i[sel*DataWidth +: DataWidth];
  assign mgr_aid_o   = MgrIdWidth'(
    {sel, sbr_aid_i[sel*SbrIdWidth +: SbrIdWidth]});

  if (UseIdForRouting != 0) begin : g_id_route
    logic idx_ok;
    assign rsp_idx  = mgr_rid_i[SbrIdWidth +: PortWidth];
    assign idx_ok   = 32'(rsp_idx) < 32'(NumSbrPorts);
    assign no_route = !idx_ok || (cnt_q[rsp_idx] == '0);
  end else begin : g_fifo_route
    logic [PortWidth-1:0] fifo_q [NumMaxTrans];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic                 unused_rid;

    function automatic logic [PtrWidth-1:0] nxt(
      input logic [PtrWidth-1:0] p
    );
      return (32'(p) == 32'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_rid = ^mgr_rid_i;
    assign rsp_idx    = fifo_q[rd_ptr_q];
    assign no_route   = total_q == '0;

    always_ff @(posedge clk_i) begin
      if (accept) fifo_q[wr_ptr_q] <= sel;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (accept) wr_ptr_q <= nxt(wr_ptr_q);
        if (rsp_hs) rd_ptr_q <= nxt(rd_ptr_q);
      end
    end
  end

  always_comb begin
    sbr_rvalid_o = '0;
    if (!no_route) sbr_rvalid_o[rsp_idx] = mgr_rvalid_i;
  end

  // Unroutable responses are drained so the manager never stalls on them.
  assign mgr_rready_o = no_route |
                        ((UseRReady != 0) ? sbr_rready_i[rsp_idx] : 1'b1);
  assign rsp_hs       = mgr_rvalid_i & mgr_rready_o & ~no_route;
  assign sbr_rid_o    = mgr_rid_i[SbrIdWidth-1:0];
  assign sbr_rdata_o  = mgr_rdata_i;
  assign sbr_err_o    = mgr_err_i;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int p = 0; p < NumSbrPorts; p++) begin
      inc_vec[p] = accept && (32'(sel) == 32'(p));
      dec_vec[p] = rsp_hs && (32'(rsp_idx) == 32'(p));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumSbrPorts; p++) cnt_q[p] <= '0;
      total_q    <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      for (int p = 0; p < NumSbrPorts; p++) begin
        if (inc_vec[p] && !dec_vec[p]) cnt_q[p] <= cnt_q[p] + 1'b1;
        else if (dec_vec[p] && !inc_vec[p]) cnt_q[p] <= cnt_q[p] - 1'b1;
      end
      if (accept && !rsp_hs) total_q <= total_q + 1'b1;
      else if (rsp_hs && !accept) total_q <= total_q - 1'b1;
      lock_q     <= mgr_req_o & ~mgr_gnt_i;
      lock_sel_q <= sel;
      if (accept) begin
        rr_q <= (32'(sel) == 32'(NumSbrPorts - 1)) ? '0 : sel + 1'b1;
      end
      if (mgr_rvalid_i && no_route) spurious_q <= 1'b1;
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int p = 0; p < NumSbrPorts; p++) begin
      outstanding_o[p*CntWidth +: CntWidth] = cnt_q[p];
    end
  end

  assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_obi_mux_credit.sv
// Directed bench for obi_mux_credit: FIFO/RR instance and ID/priority
// instance, responses checked against a port-order scoreboard queue.
module tb_obi_mux_credit;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] addr;
  logic [3:0]   we;
  logic [15:0]  be;
  logic [127:0] wdata;
  logic [3:0]   aid;
  logic [3:0]   rready;
  logic [31:0]  rdata;
  logic         err;

  logic [3:0]  req_a, sgnt_a, srv_a;
  logic        gnt_a, rv_a, serr_a, srid_a;
  logic        mreq_a, mwe_a, mrr_a, spur_a;
  logic [2:0]  rid_a, maid_a;
  logic [31:0] srdata_a, maddr_a, mwdata_a;
  logic [3:0]  mbe_a;
  logic [11:0] out_a;

  logic [3:0]  req_b, sgnt_b, srv_b;
  logic        gnt_b, rv_b, serr_b, srid_b;
  logic        mreq_b, mwe_b, mrr_b, spur_b;
  logic [2:0]  rid_b, maid_b;
  logic [31:0] srdata_b, maddr_b, mwdata_b;
  logic [3:0]  mbe_b;
  logic [11:0] out_b;

  int total = 0;
  int bad   = 0;
  int rspq[$];
  int gq[$];
  int e;

  always #5 clk = ~clk;

  obi_mux_credit dut_a (
    .clk_i(clk), .rst_i(rst),
    .sbr_req_i(req_a), .sbr_gnt_o(sgnt_a),
    .sbr_addr_i(addr), .sbr_we_i(we), .sbr_be_i(be),
    .sbr_wdata_i(wdata), .sbr_aid_i(aid),
    .sbr_rvalid_o(srv_a), .sbr_rready_i(rready),
    .sbr_rdata_o(srdata_a), .sbr_err_o(serr_a), .sbr_rid_o(srid_a),
    .mgr_req_o(mreq_a), .mgr_gnt_i(gnt_a),
    .mgr_addr_o(maddr_a), .mgr_we_o(mwe_a), .mgr_be_o(mbe_a),
    .mgr_wdata_o(mwdata_a), .mgr_aid_o(maid_a),
    .mgr_rvalid_i(rv_a), .mgr_rready_o(mrr_a),
    .mgr_rdata_i(rdata), .mgr_err_i(err), .mgr_rid_i(rid_a),
    .outstanding_o(out_a), .spurious_rsp_o(spur_a)
  );

  obi_mux_credit #(
    .PriorityMode(1), .UseIdForRouting(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .sbr_req_i(req_b), .sbr_gnt_o(sgnt_b),
    .sbr_addr_i(addr), .sbr_we_i(we), .sbr_be_i(be),
    .sbr_wdata_i(wdata), .sbr_aid_i(aid),
    .sbr_rvalid_o(srv_b), .sbr_rready_i(rready),
    .sbr_rdata_o(srdata_b), .sbr_err_o(serr_b), .sbr_rid_o(srid_b),
    .mgr_req_o(mreq_b), .mgr_gnt_i(gnt_b),
    .mgr_addr_o(maddr_b), .mgr_we_o(mwe_b), .mgr_be_o(mbe_b),
    .mgr_wdata_o(mwdata_b), .mgr_aid_o(maid_b),
    .mgr_rvalid_i(rv_b), .mgr_rready_o(mrr_b),
    .mgr_rdata_i(rdata), .mgr_err_i(err), .mgr_rid_i(rid_b),
    .outstanding_o(out_b), .spurious_rsp_o(spur_b)
  );

  function automatic logic [31:0] addr_of(input int p);
    return 32'hA000_0000 + 32'(p * 'h100);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      addr[p*32 +: 32]  = addr_of(p);
      wdata[p*32 +: 32] = 32'h1111_0000 + 32'(p);
    end
    we = 4'b1010; be = 16'hF3C1; aid = 4'b0101;
    rready = 4'hF; rdata = '0; err = 1'b0;
    req_a = '0; gnt_a = 1'b0; rv_a = 1'b0; rid_a = '0;
    req_b = '0; gnt_b = 1'b0; rv_b = 1'b0; rid_b = '0;

    step();
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_mreq", mreq_a, 0);
    chk("rst_gnt", sgnt_a, 0);
    chk("rst_rv", srv_a, 0);
    chk("rst_spur", spur_a, 0);
    rst = 1'b0;
    step();

    // credit limit on a single port
    req_a = 4'b0010; gnt_a = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("cr_gnt", sgnt_a, 4'b0010);
      chk("cr_addr", maddr_a, addr_of(1));
      rspq.push_back(1);
      step();
    end
    chk("cr_cnt", out_a[5:3], 4);
    chk("cr_hold", sgnt_a, 0);
    chk("cr_mreq", mreq_a, 0);
    step();
    chk("cr_hold2", sgnt_a, 0);
    rv_a = 1'b1; #1;
    e = rspq.pop_front();
    chk("cr_rv", srv_a, 64'(1) << e);
    chk("cr_blk", sgnt_a, 0);
    step();
    rv_a = 1'b0; #1;
    chk("cr_regrant", sgnt_a, 4'b0010);
    chk("cr_cnt3", out_a[5:3], 3);
    req_a = '0;
    for (int i = 0; i < 3; i++) begin
      rv_a = 1'b1; #1;
      e = rspq.pop_front();
      chk("cr_drain", srv_a, 64'(1) << e);
      step();
    end
    rv_a = 1'b0; #1;
    chk("cr_empty", out_a, 0);

    // round-robin from a fresh pointer
    rst = 1'b1; #2; rst = 1'b0;
    gq = '{0, 1, 2, 3, 0};
    req_a = 4'hF; #1;
    for (int i = 0; i < 5; i++) begin
      e = gq.pop_front();
      rspq.push_back(e);
      chk("rr_gnt", sgnt_a, 64'(1) << e);
      step();
    end
    req_a = '0; #1;
    chk("rr_cnt", out_a, 12'b001_001_001_010);
    for (int i = 0; i < 5; i++) begin
      rv_a = 1'b1; #1;
      e = rspq.pop_front();
      chk("rr_rsp", srv_a, 64'(1) << e);
      step();
    end
    rv_a = 1'b0;

    // in-order FIFO routing 3,0,3 with a stall on port 0
    req_a = 4'b1000; #1;
    chk("ff_g3", sgnt_a, 4'b1000); rspq.push_back(3); step();
    req_a = 4'b0001; #1;
    chk("ff_g0", sgnt_a, 4'b0001); rspq.push_back(0); step();
    req_a = 4'b1000; #1;
    chk("ff_g3b", sgnt_a, 4'b1000); rspq.push_back(3); step();
    req_a = '0; rv_a = 1'b1; #1;
    e = rspq.pop_front();
    chk("ff_rv1", srv_a, 64'(1) << e);
    step();
    rready = 4'b1110; #1;
    chk("ff_stall_rv", srv_a, 64'(1) << rspq[0]);
    chk("ff_stall1", mrr_a, 0);
    step();
    chk("ff_stall2", mrr_a, 0);
    step();
    rready = 4'hF; #1;
    chk("ff_go", mrr_a, 1);
    e = rspq.pop_front();
    chk("ff_rv2", srv_a, 64'(1) << e);
    step();
    e = rspq.pop_front();
    chk("ff_rv3", srv_a, 64'(1) << e);
    step();
    rv_a = 1'b0; #1;
    chk("ff_empty", out_a, 0);

    // accept and response on port 0 in one cycle
    req_a = 4'b0001; #1;
    chk("sim_g1", sgnt_a, 4'b0001); rspq.push_back(0); step();
    chk("sim_g2", sgnt_a, 4'b0001); rspq.push_back(0); step();
    rv_a = 1'b1; #1;
    e = rspq.pop_front();
    chk("sim_rv", srv_a, 64'(1) << e);
    chk("sim_g3", sgnt_a, 4'b0001); rspq.push_back(0);
    step();
    req_a = '0; rv_a = 1'b0; #1;
    chk("sim_cnt", out_a, 12'd2);

    // reset in the middle of a burst
    req_a = 4'hF; step();
    rst = 1'b1; #1;
    chk("mid_rst_cnt", out_a, 0);
    chk("mid_rst_spur", spur_a, 0);
    rspq.delete();
    step();
    rst = 1'b0; req_a = 4'b0100; gnt_a = 1'b0; #1;
    chk("mid_mreq", mreq_a, 1);
    chk("mid_addr", maddr_a, addr_of(2));

    // lock-in while the manager withholds the grant
    step();
    req_a = 4'b0101; #1;
    chk("lk_addr1", maddr_a, addr_of(2));
    chk("lk_gnt1", sgnt_a, 0);
    step();
    chk("lk_addr2", maddr_a, addr_of(2));
    step();
    gnt_a = 1'b1; #1;
    chk("lk_gnt4", sgnt_a, 4'b0100);
    chk("lk_addr4", maddr_a, addr_of(2));
    rspq.push_back(2);
    step();
    chk("lk_next", sgnt_a, 4'b0001);
    rspq.push_back(0);
    step();
    req_a = '0;
    for (int i = 0; i < 2; i++) begin
      rv_a = 1'b1; #1;
      e = rspq.pop_front();
      chk("lk_rsp", srv_a, 64'(1) << e);
      step();
    end

    // response with nothing outstanding
    rdata = 32'hDEAD_BEEF; #1;
    chk("sp_rv", srv_a, 0);
    chk("sp_rr", mrr_a, 1);
    chk("sp_data", srdata_a, 32'hDEAD_BEEF);
    step();
    rv_a = 1'b0; #1;
    chk("sp_flag", spur_a, 1);
    chk("sp_cnt", out_a, 0);

    // fixed priority and ID routing
    chk("b_idle", out_b, 0);
    req_b = 4'hF; gnt_b = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("fp_gnt", sgnt_b, 4'b0001);
      chk("fp_aid", maid_b, 3'b001);
      step();
    end
    chk("fp_credit", sgnt_b, 4'b0010);
    chk("fp_aid1", maid_b, 3'b010);
    step();
    req_b = '0; #1;
    chk("fp_cnt", out_b, 12'b000_000_001_100);
    rv_b = 1'b1; rid_b = 3'b001; rready = 4'b1110; #1;
    chk("id_rv0", srv_b, 4'b0001);
    chk("id_stall", mrr_b, 0);
    step();
    rready = 4'hF; #1;
    chk("id_go", mrr_b, 1);
    chk("id_rid1", srid_b, 1);
    step();
    rid_b = 3'b010; #1;
    chk("id_rv1", srv_b, 4'b0010);
    chk("id_rid0", srid_b, 0);
    step();
    rv_b = 1'b0; #1;
    chk("id_cnt", out_b, 12'b000_000_000_011);
    req_b = 4'b0100; #1;
    chk("id_g2", sgnt_b, 4'b0100);
    chk("id_aid2", maid_b, 3'b101);
    step();
    req_b = '0; rv_b = 1'b1; rid_b = 3'b101; #1;
    chk("id_rv2", srv_b, 4'b0100);
    chk("id_rid2", srid_b, 1);
    step();
    chk("id_sp_rv", srv_b, 0);
    chk("id_sp_rr", mrr_b, 1);
    chk("id_sp_pre", spur_b, 0);
    step();
    rv_b = 1'b0; #1;
    chk("id_sp_flag", spur_b, 1);
    chk("id_sp_cnt", out_b, 12'b000_000_000_011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
